serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial, LSB-first subtractor: computes `d = a - b - bi` over WIDTH clock cycles using a single full-subtractor cell and a registered borrow. It is the arithmetic counterpart of the combinational full adder in the same arithmetic library. It is intended for area-constrained datapaths that can trade latency for logic. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operands a, b, bi are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bi  input  1  borrow in.
- out_valid  output  1  d and bo hold a completed result.
- out_ready  input  1  downstream accepts result.
- d  output  WIDTH  difference, modulo 2^WIDTH.
- bo  output  1  borrow out; 1 iff a < b + bi (unsigned).

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE→SHIFT on edge with in_valid && in_ready:
  - latch a→sa, b→sb, bi→br.
  - clear bit counter cnt (width $clog2(WIDTH+1)).
- SHIFT, each edge:
  - bit function: s = sa[0]^sb[0]^br.
  - borrow update: br ← (~sa[0]&sb[0]) | (~sa[0]&br) | (sb[0]&br).
  - d ← {s, d[WIDTH-1:1]}; sa, sb shift right by 1; cnt ← cnt+1.
- SHIFT→DONE on the edge processing bit WIDTH-1 (cnt == WIDTH-1). At that edge, bo ← final borrow.
- DONE→IDLE on edge with out_ready=1. d and bo retain their values in IDLE until the next SHIFT overwrites d.
- In DONE with out_ready=0, d, bo, and out_valid hold stable indefinitely.
- in_valid outside IDLE is ignored; no queuing, no data loss semantics owed to the upstream beyond the handshake.
- d contents during SHIFT are partial and not meaningful (out_valid=0).
- Reset (rst_n=0 at an edge), from any state and mid-operation:
  - state←IDLE, d←0, bo←0, br←0, cnt←0.
  - The in-flight operation is discarded.
  - An in_valid coincident with the reset edge is not accepted.
- Reset values: in_ready=1 (IDLE), out_valid=0, d=0, bo=0.

## Timing
- Accept edge E0. Bits are processed on edges E1..EWIDTH. out_valid is high in the cycle following EWIDTH, i.e. WIDTH edges after accept.
- in_ready and out_valid are decoded directly from the state register (no combinational path from in_valid/out_ready).
- No same-cycle pass-through: DONE→IDLE consumes one edge, and a new accept needs a further edge.
- Minimum initiation interval with out_ready tied high is WIDTH+2 cycles.
- WIDTH=1: one SHIFT edge, then DONE.

## Test plan
- Reset, plus in_valid held high during reset:
  - While rst_n=0 for 2 edges with in_valid=1: out_valid=0, d=0x00, bo=0, no accept.
  - After release: in_ready=1.
- WIDTH=8, a=0x5A, b=0x23, bi=0 → d=0x37, bo=0; out_valid rises exactly 8 edges after accept.
- Underflow and borrow-in:
  - a=0x00, b=0x01, bi=0 → d=0xFF, bo=1.
  - a=0x10, b=0x0F, bi=1 → d=0x00, bo=0.
- Backpressure: result 0x37 held with out_ready=0 for 5 cycles; in_valid pulsed with new operands during that time.
  - Required: d=0x37, bo=0, out_valid=1 stable; in_ready=0; new operands not latched.
  - After out_ready=1: IDLE on next edge.
- Reset mid-operation: rst_n=0 during SHIFT with cnt=3.
  - Required: next state IDLE, out_valid=0, d=0, bo=0.
  - Following op a=0xFF, b=0xFF, bi=1 → d=0xFF, bo=1.
- Back-to-back ops, out_ready tied 1, in_valid tied 1:
  - Accepts occur every 10 cycles (WIDTH+2).
  - 16 random (a, b, bi) triples match the reference model (a-b-bi) mod 256 and borrow.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: d = a - b - bi over WIDTH cycles using one
// full-subtractor cell, with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] d_next;

  // One full-subtractor cell; the new bit enters d at the MSB so that after
  // WIDTH shifts the LSB-first results sit in their natural positions.
  always_comb begin
    diff_bit    = sa[0] ^ sb[0] ^ br;
    borrow_next = (~sa[0] & sb[0]) | (~sa[0] & br) | (sb[0] & br);
    d_next      = WIDTH'({diff_bit, d} >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bo    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa    <= a;
            sb    <= b;
            br    <= bi;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          d   <= d_next;
          br  <= borrow_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            bo    <= borrow_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come straight from the state register, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
